cond_flag_unit: RTL and testbench

- Consumes the 64-bit ALU status flags (negative, zero, overflow, carry_out) from the EX stage of the 5-stage pipeline.
- Holds the architectural NZCV flag register.
- Evaluates branch conditions for B, B.cond, CBZ and CBNZ, and returns a registered taken/not-taken decision to the fetch/PC logic.
- Keeps saturating taken/not-taken counters for performance debug.

---
 rtl/cond_flag_unit.sv | 138 +++++++++++++
 tb/tb_cond_flag_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// Branch condition unit: architectural NZCV register with EX forwarding,
// registered one-cycle branch decision and saturating taken/not-taken counters.
module cond_flag_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic             ex_negative,
  input  logic             ex_zero,
  input  logic             ex_overflow,
  input  logic             ex_carry_out,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  input  logic             br_reg_zero,
  output logic             br_taken,
  output logic             br_done,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_HS, CC_LO, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  logic [3:0]       flags_d;
  logic             br_taken_q, br_taken_d;
  logic             br_done_q, br_done_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

  logic [3:0] ex_flags;
  logic [3:0] eff_flags;
  logic       eff_n, eff_z, eff_c, eff_v;
  logic       ex_flag_wr;
  logic       cond_pass;
  logic       decision;
  logic       accept;

  assign ex_flags   = {ex_negative, ex_zero, ex_carry_out, ex_overflow};
  assign ex_flag_wr = ex_valid & ex_set_flags;
  // Forward the EX result so a B.cond right behind ADDS/SUBS needs no bubble.
  assign eff_flags  = ex_flag_wr ? ex_flags : flags_q;
  assign {eff_n, eff_z, eff_c, eff_v} = eff_flags;
  assign accept     = br_valid & ~stall & ~flush;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(br_cond))
      CC_EQ: cond_pass = eff_z;
      CC_NE: cond_pass = ~eff_z;
      CC_HS: cond_pass = eff_c;
      CC_LO: cond_pass = ~eff_c;
      CC_MI: cond_pass = eff_n;
      CC_PL: cond_pass = ~eff_n;
      CC_VS: cond_pass = eff_v;
      CC_VC: cond_pass = ~eff_v;
      CC_HI: cond_pass = eff_c & ~eff_z;
      CC_LS: cond_pass = ~(eff_c & ~eff_z);
      CC_GE: cond_pass = (eff_n == eff_v);
      CC_LT: cond_pass = (eff_n != eff_v);
      CC_GT: cond_pass = ~eff_z & (eff_n == eff_v);
      CC_LE: cond_pass = ~(~eff_z & (eff_n == eff_v));
      CC_AL: cond_pass = 1'b1;
      CC_NV: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    decision = 1'b0;
    case (br_type_e'(br_type))
      BR_B:    decision = 1'b1;
      BR_COND: decision = cond_pass;
      BR_CBZ:  decision = br_reg_zero;
      BR_CBNZ: decision = ~br_reg_zero;
      default: decision = 1'b0;
    endcase
  end

  always_comb begin
    flags_d        = flags_q;
    br_done_d      = br_done_q;
    br_taken_d     = br_taken_q;
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    // Flush only kills the branch; the EX flag write has already committed.
    if (ex_flag_wr && !stall) begin
      flags_d = ex_flags;
    end
    if (!stall) begin
      br_done_d  = accept;
      br_taken_d = accept & decision;
    end
    if (accept) begin
      if (decision) begin
        if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end else begin
        if (nottaken_cnt_q != '1) nottaken_cnt_d = nottaken_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q        <= '0;
      br_done_q      <= 1'b0;
      br_taken_q     <= 1'b0;
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      flags_q        <= flags_d;
      br_done_q      <= br_done_d;
      br_taken_q     <= br_taken_d;
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  assign br_done      = br_done_q;
  assign br_taken     = br_taken_q;
  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: vector table for flag/condition decisions,
// hand sequences for stall/flush, async reset and counter saturation.
module tb_cond_flag_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        ex_valid, ex_set_flags;
  logic        ex_negative, ex_zero, ex_overflow, ex_carry_out;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [3:0]  br_cond;
  logic        br_reg_zero;

  logic        br_taken, br_done;
  logic [3:0]  flags_q;
  logic [15:0] taken_cnt, nottaken_cnt;

  logic        s_br_taken, s_br_done;
  logic [3:0]  s_flags_q;
  logic [3:0]  s_taken_cnt, s_nottaken_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned exp_tk = 0;
  int unsigned exp_nt = 0;

  always #5 clk = ~clk;

  cond_flag_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .ex_negative(ex_negative), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
    .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond),
    .br_reg_zero(br_reg_zero),
    .br_taken(br_taken), .br_done(br_done), .flags_q(flags_q),
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  cond_flag_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .ex_negative(ex_negative), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out),
    .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond),
    .br_reg_zero(br_reg_zero),
    .br_taken(s_br_taken), .br_done(s_br_done), .flags_q(s_flags_q),
    .taken_cnt(s_taken_cnt), .nottaken_cnt(s_nottaken_cnt)
  );

  typedef struct {
    logic       exv;
    logic       exs;
    logic [3:0] nzcv;
    logic       bv;
    logic [1:0] bt;
    logic [3:0] cc;
    logic       rz;
    logic       e_done;
    logic       e_taken;
    logic [3:0] e_flags;
  } vec_t;

  vec_t vt[29];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0; ex_valid = 0; ex_set_flags = 0;
    {ex_negative, ex_zero, ex_carry_out, ex_overflow} = 4'b0000;
    br_valid = 0; br_type = 2'b00; br_cond = 4'h0; br_reg_zero = 0;
  endtask

  task automatic set_ex(input logic v, input logic s, input logic [3:0] f);
    ex_valid = v; ex_set_flags = s;
    {ex_negative, ex_zero, ex_carry_out, ex_overflow} = f;
  endtask

  task automatic set_br(input logic v, input logic [1:0] t, input logic [3:0] c, input logic rz);
    br_valid = v; br_type = t; br_cond = c; br_reg_zero = rz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_taken_cnt"}, 32'(taken_cnt), exp_tk);
    chk({tag, "_nottaken_cnt"}, 32'(nottaken_cnt), exp_nt);
  endtask

  initial begin
    //        exv exs nzcv     bv bt     cc    rz done tk flags
    vt[0]  = '{1, 1, 4'b1000, 1, 2'b01, 4'hB, 0, 1, 1, 4'b1000}; // SUBS 1-2 fwd, LT
    vt[1]  = '{1, 1, 4'b0110, 0, 2'b00, 4'h0, 0, 0, 0, 4'b0110}; // SUBS 1-1
    vt[2]  = '{0, 0, 4'b0000, 0, 2'b00, 4'h0, 0, 0, 0, 4'b0110};
    vt[3]  = '{0, 0, 4'b0000, 1, 2'b01, 4'h0, 0, 1, 1, 4'b0110}; // EQ
    vt[4]  = '{0, 0, 4'b0000, 1, 2'b01, 4'h1, 0, 1, 0, 4'b0110}; // NE
    vt[5]  = '{0, 0, 4'b0000, 1, 2'b01, 4'h8, 0, 1, 0, 4'b0110}; // HI
    vt[6]  = '{0, 0, 4'b0000, 1, 2'b01, 4'hA, 0, 1, 1, 4'b0110}; // GE
    vt[7]  = '{0, 0, 4'b0000, 1, 2'b10, 4'h0, 1, 1, 1, 4'b0110}; // CBZ rz=1
    vt[8]  = '{0, 0, 4'b0000, 1, 2'b11, 4'h0, 1, 1, 0, 4'b0110}; // CBNZ rz=1
    vt[9]  = '{0, 0, 4'b0000, 1, 2'b10, 4'h0, 0, 1, 0, 4'b0110}; // CBZ rz=0
    vt[10] = '{0, 0, 4'b0000, 1, 2'b00, 4'h1, 0, 1, 1, 4'b0110}; // B ignores cond
    vt[11] = '{1, 1, 4'b0011, 1, 2'b01, 4'hC, 0, 1, 0, 4'b0011}; // fwd GT
    vt[12] = '{0, 0, 4'b0000, 1, 2'b01, 4'hD, 0, 1, 1, 4'b0011}; // LE
    vt[13] = '{0, 0, 4'b0000, 1, 2'b01, 4'h6, 0, 1, 1, 4'b0011}; // VS
    vt[14] = '{0, 0, 4'b0000, 1, 2'b01, 4'h7, 0, 1, 0, 4'b0011}; // VC
    vt[15] = '{0, 0, 4'b0000, 1, 2'b01, 4'h2, 0, 1, 1, 4'b0011}; // HS
    vt[16] = '{0, 0, 4'b0000, 1, 2'b01, 4'h3, 0, 1, 0, 4'b0011}; // LO
    vt[17] = '{0, 0, 4'b0000, 1, 2'b01, 4'h4, 0, 1, 0, 4'b0011}; // MI
    vt[18] = '{0, 0, 4'b0000, 1, 2'b01, 4'h5, 0, 1, 1, 4'b0011}; // PL
    vt[19] = '{0, 0, 4'b0000, 1, 2'b01, 4'h9, 0, 1, 0, 4'b0011}; // LS
    vt[20] = '{0, 0, 4'b0000, 1, 2'b01, 4'hB, 0, 1, 1, 4'b0011}; // LT
    vt[21] = '{0, 0, 4'b0000, 1, 2'b01, 4'hE, 0, 1, 1, 4'b0011}; // AL
    vt[22] = '{0, 0, 4'b0000, 1, 2'b01, 4'hF, 0, 1, 1, 4'b0011}; // NV
    vt[23] = '{0, 1, 4'b1111, 1, 2'b01, 4'h0, 0, 1, 0, 4'b0011}; // set_flags w/o valid
    vt[24] = '{1, 0, 4'b0100, 1, 2'b01, 4'h1, 0, 1, 1, 4'b0011}; // valid, not flag-setting
    vt[25] = '{1, 1, 4'b0100, 1, 2'b01, 4'h8, 0, 1, 0, 4'b0100}; // fwd HI
    vt[26] = '{1, 1, 4'b1001, 1, 2'b01, 4'hA, 0, 1, 1, 4'b1001}; // fwd GE
    vt[27] = '{1, 1, 4'b1001, 1, 2'b01, 4'hC, 0, 1, 1, 4'b1001}; // fwd GT
    vt[28] = '{0, 0, 4'b0000, 1, 2'b01, 4'h4, 0, 1, 1, 4'b1001}; // MI

    idle();
    reset = 1;
    #12;
    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_done", 32'(br_done), 32'h0);
    chk("rst_taken", 32'(br_taken), 32'h0);
    chk_cnt("rst");
    reset = 0;
    tick();

    for (int i = 0; i < 29; i++) begin
      set_ex(vt[i].exv, vt[i].exs, vt[i].nzcv);
      set_br(vt[i].bv, vt[i].bt, vt[i].cc, vt[i].rz);
      if (vt[i].bv) begin
        if (vt[i].e_taken) exp_tk++;
        else exp_nt++;
      end
      tick();
      chk($sformatf("v%0d_done", i), 32'(br_done), 32'(vt[i].e_done));
      chk($sformatf("v%0d_taken", i), 32'(br_taken), 32'(vt[i].e_taken));
      chk($sformatf("v%0d_flags", i), 32'(flags_q), 32'(vt[i].e_flags));
    end
    chk_cnt("table");

    // Stall: query and flag write ignored, outputs hold previous taken decision.
    stall = 1;
    set_ex(1, 1, 4'b1111);
    set_br(1, 2'b11, 4'h0, 1);
    tick();
    chk("stall_done", 32'(br_done), 32'h1);
    chk("stall_taken", 32'(br_taken), 32'h1);
    chk("stall_flags", 32'(flags_q), 32'b1001);
    chk_cnt("stall");

    flush = 1;
    set_br(1, 2'b00, 4'h0, 0);
    tick();
    chk("stallflush_done", 32'(br_done), 32'h1);
    chk("stallflush_flags", 32'(flags_q), 32'b1001);
    chk_cnt("stallflush");

    stall = 0;
    set_ex(1, 1, 4'b0110);
    tick();
    chk("flush_done", 32'(br_done), 32'h0);
    chk("flush_taken", 32'(br_taken), 32'h0);
    chk("flush_flags", 32'(flags_q), 32'b0110);
    chk_cnt("flush");

    idle();
    set_br(1, 2'b00, 4'h0, 0);
    exp_tk++;
    tick();
    chk("post_flush_done", 32'(br_done), 32'h1);
    chk("post_flush_taken", 32'(br_taken), 32'h1);
    chk_cnt("post_flush");

    // Async reset mid-cycle after three taken branches.
    idle();
    reset = 1;
    tick();
    reset = 0;
    exp_tk = 0; exp_nt = 0;
    set_ex(1, 1, 4'b1010);
    set_br(1, 2'b00, 4'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      set_ex(0, 0, 4'b0000);
    end
    exp_tk = 3;
    chk("pre_rst_flags", 32'(flags_q), 32'b1010);
    chk_cnt("pre_rst");
    #2;
    reset = 1;
    #1;
    chk("async_rst_flags", 32'(flags_q), 32'h0);
    chk("async_rst_done", 32'(br_done), 32'h0);
    chk("async_rst_taken_cnt", 32'(taken_cnt), 32'h0);
    idle();
    tick();
    reset = 0;
    tick();
    chk("post_rst_done", 32'(br_done), 32'h0);
    chk("post_rst_taken_cnt", 32'(taken_cnt), 32'h0);

    // Saturation of the narrow counter instance.
    set_br(1, 2'b00, 4'h0, 0);
    for (int i = 0; i < 20; i++) tick();
    idle();
    tick();
    chk("sat_taken_cnt", 32'(s_taken_cnt), 32'hF);
    chk("sat_nottaken_cnt", 32'(s_nottaken_cnt), 32'h0);
    chk("wide_taken_cnt", 32'(taken_cnt), 32'd20);
    chk("sat_done_idle", 32'(s_br_done), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
